// File: rtl/run_sequencer.sv
// ============================================================================
// Module      : run_sequencer
// Description : Program sequencer for the 9-bit-instruction core: PC, start/done
//               handshake, stall, branch redirect, halt detect, PC-wrap fault.
//               Optional cycle counter enabled by RUN_SEQUENCER_CYCLE_COUNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module run_sequencer #(
  parameter int                    PC_WIDTH   = 11,
  parameter int                    INST_WIDTH = 9,
  parameter logic [PC_WIDTH-1:0]   START_ADDR = '0,
  parameter logic [INST_WIDTH-1:0] HALT_INST  = {INST_WIDTH{1'b1}},
  parameter int                    CYC_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  stall,
  input  logic                  branch_en,
  input  logic [PC_WIDTH-1:0]   target,
  input  logic [INST_WIDTH-1:0] inst_in,
  output logic [PC_WIDTH-1:0]   pc,
  output logic                  running,
  output logic                  done,
  output logic                  fault,
  output logic [CYC_WIDTH-1:0]  cycle_count
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [PC_WIDTH-1:0] c_PC_MAX = {PC_WIDTH{1'b1}};

  state_t              r_state;
  logic [PC_WIDTH-1:0] r_pc;
  logic                r_running;
  logic                r_done;
  logic                r_fault;

  // A stalled cycle is invisible to the program: no fetch advance, no halt check.
  logic w_step;
  assign w_step = !start && (r_state == S_RUN) && !stall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_pc      <= START_ADDR;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
    end else if (start) begin
      r_state   <= S_ARMED;
      r_pc      <= START_ADDR;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      case (r_state)
        S_ARMED: begin
          r_state   <= S_RUN;
          r_running <= 1'b1;
        end
        S_RUN: begin
          if (w_step) begin
            if (inst_in == HALT_INST) begin
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
            end else if (branch_en) begin
              r_pc <= target;
            end else if (r_pc == c_PC_MAX) begin
              // Running off the end of the address space is a fault, not a wrap.
              r_state   <= S_DONE;
              r_running <= 1'b0;
              r_done    <= 1'b1;
              r_fault   <= 1'b1;
            end else begin
              r_pc <= r_pc + PC_WIDTH'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
  localparam logic [CYC_WIDTH-1:0] c_CYC_MAX = {CYC_WIDTH{1'b1}};

  logic [CYC_WIDTH-1:0] r_cycle_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cycle_count <= '0;
    end else if (start) begin
      r_cycle_count <= '0;
    end else if (w_step && (r_cycle_count != c_CYC_MAX)) begin
      r_cycle_count <= r_cycle_count + CYC_WIDTH'(1);
    end
  end

  assign cycle_count = r_cycle_count;
`else
  assign cycle_count = '0;
`endif

  assign pc      = r_pc;
  assign running = r_running;
  assign done    = r_done;
  assign fault   = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_run_sequencer.sv
// ============================================================================
// Module      : tb_run_sequencer
// Description : Directed self-checking bench for run_sequencer (11-bit and
//               4-bit PC instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_run_sequencer;

`ifdef RUN_SEQUENCER_CYCLE_COUNT_EN
  localparam bit c_CNT_EN = 1'b1;
`else
  localparam bit c_CNT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start, stall, branch_en;
  logic [10:0] target;
  logic [8:0]  inst;
  logic [10:0] pc;
  logic        running, done, fault;
  logic [15:0] cycle_count;

  logic        start4;
  logic [8:0]  inst4;
  logic [3:0]  pc4;
  logic        running4, done4, fault4;
  logic [15:0] cycle_count4;
  logic [3:0]  zero4;

  logic [8:0]  rom [0:2047];

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  assign inst  = rom[pc];
  assign inst4 = 9'h000;
  assign zero4 = 4'h0;

  run_sequencer u_dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall),
    .branch_en(branch_en), .target(target), .inst_in(inst),
    .pc(pc), .running(running), .done(done), .fault(fault),
    .cycle_count(cycle_count)
  );

  run_sequencer #(.PC_WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .stall(1'b0),
    .branch_en(1'b0), .target(zero4), .inst_in(inst4),
    .pc(pc4), .running(running4), .done(done4), .fault(fault4),
    .cycle_count(cycle_count4)
  );

  function automatic logic [31:0] cnt(input int v);
    return c_CNT_EN ? 32'(v) : 32'd0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    for (int i = 0; i < 2048; i++) rom[i] = 9'h000;
    reset = 1'b1; start = 1'b0; start4 = 1'b0; stall = 1'b0;
    branch_en = 1'b0; target = 11'h000;
    #2;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_running", 32'(running), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_count", 32'(cycle_count), 32'd0);
    tick();
    reset = 1'b0;

    // Wrap fault on the 4-bit instance
    start4 = 1'b1; tick();
    start4 = 1'b0; tick();
    chk("wrap_run", 32'(running4), 32'd1);
    chk("wrap_pc0", 32'(pc4), 32'd0);
    tick(15);
    chk("wrap_pc15", 32'(pc4), 32'd15);
    chk("wrap_nodone", 32'(done4), 32'd0);
    tick();
    chk("wrap_done", 32'(done4), 32'd1);
    chk("wrap_fault", 32'(fault4), 32'd1);
    chk("wrap_pc", 32'(pc4), 32'd15);
    chk("wrap_count", 32'(cycle_count4), cnt(16));
    chk("wrap_running", 32'(running4), 32'd0);

    // Linear run, halt at address 4
    rom[4] = 9'h1FF;
    start = 1'b1; tick(2);
    chk("arm_pc", 32'(pc), 32'd0);
    chk("arm_running", 32'(running), 32'd0);
    start = 1'b0; tick();
    chk("lin_running", 32'(running), 32'd1);
    chk("lin_pc0", 32'(pc), 32'd0);
    tick();
    chk("lin_pc1", 32'(pc), 32'd1);
    tick(3);
    chk("lin_pc4", 32'(pc), 32'd4);
    chk("lin_nodone", 32'(done), 32'd0);
    tick();
    chk("lin_done", 32'(done), 32'd1);
    chk("lin_running0", 32'(running), 32'd0);
    chk("lin_pc", 32'(pc), 32'd4);
    chk("lin_count", 32'(cycle_count), cnt(5));
    chk("lin_fault", 32'(fault), 32'd0);
    tick(2);
    chk("lin_sticky", 32'(done), 32'd1);
    chk("lin_frozen", 32'(pc), 32'd4);

    // Branch, then branch together with halt
    rom[4] = 9'h000;
    start = 1'b1; tick();
    chk("rearm_done", 32'(done), 32'd0);
    chk("rearm_count", 32'(cycle_count), 32'd0);
    start = 1'b0; tick(3);
    chk("br_pc2", 32'(pc), 32'd2);
    branch_en = 1'b1; target = 11'h020; tick();
    chk("br_pc", 32'(pc), 32'h20);
    rom[11'h020] = 9'h1FF; target = 11'h040; tick();
    chk("brhalt_done", 32'(done), 32'd1);
    chk("brhalt_pc", 32'(pc), 32'h20);
    chk("brhalt_count", 32'(cycle_count), cnt(4));
    branch_en = 1'b0; target = 11'h000;

    // Stall holds halt evaluation, PC and counter; branch ignored while stalled
    rom[11'h020] = 9'h000; rom[3] = 9'h1FF;
    start = 1'b1; tick();
    start = 1'b0; tick(4);
    chk("st_pc3", 32'(pc), 32'd3);
    stall = 1'b1; branch_en = 1'b1; target = 11'h100;
    for (int s = 0; s < 3; s++) begin
      tick();
      chk("st_pc", 32'(pc), 32'd3);
      chk("st_nodone", 32'(done), 32'd0);
      chk("st_count", 32'(cycle_count), cnt(3));
    end
    stall = 1'b0; branch_en = 1'b0; target = 11'h000; tick();
    chk("st_done", 32'(done), 32'd1);
    chk("st_pc_done", 32'(pc), 32'd3);
    chk("st_count_done", 32'(cycle_count), cnt(4));

    // Abort a run with start
    rom[3] = 9'h000;
    start = 1'b1; tick();
    start = 1'b0; tick(8);
    chk("ab_pc7", 32'(pc), 32'd7);
    chk("ab_count7", 32'(cycle_count), cnt(7));
    start = 1'b1; tick();
    chk("ab_running", 32'(running), 32'd0);
    chk("ab_pc", 32'(pc), 32'd0);
    chk("ab_count", 32'(cycle_count), 32'd0);
    tick();
    chk("ab_hold_pc", 32'(pc), 32'd0);
    chk("ab_hold_running", 32'(running), 32'd0);

    // Asynchronous reset mid-run
    start = 1'b0; tick(6);
    chk("mr_pc5", 32'(pc), 32'd5);
    #2 reset = 1'b1;
    #1;
    chk("mr_pc", 32'(pc), 32'd0);
    chk("mr_running", 32'(running), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_count", 32'(cycle_count), 32'd0);
    tick();
    reset = 1'b0; tick(2);
    chk("mr_idle_pc", 32'(pc), 32'd0);
    chk("mr_idle_running", 32'(running), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/run_sequencer.md
# run_sequencer

Parametrised program sequencer for the 9-bit-instruction core: it owns the program counter, the start/done handshake, stall and branch redirection, halt detection and an optional cycle counter. It sits between the instruction ROM, which it addresses with `pc` and receives `inst_in` from, and the control/branch LUT path, which supplies `branch_en`/`target`. It generalises the fixed-width fetch-and-done logic with configurable widths, a start address, a halt opcode, stall support and a PC-overflow fault.

## Interface
Parameters:
- `PC_WIDTH`, 11: program counter width.
- `INST_WIDTH`, 9: instruction word width.
- `START_ADDR`, 0: PC load value on reset and arm.
- `HALT_INST`, all ones (`{INST_WIDTH{1'b1}}`): instruction encoding that ends the program.
- `CYC_WIDTH`, 16: cycle counter width.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  level; high = arm/hold, falling to low = begin run.
- `stall`  in  1  freeze PC and halt evaluation this cycle.
- `branch_en`  in  1  redirect PC to `target` this cycle.
- `target`  in  PC_WIDTH  branch destination.
- `inst_in`  in  INST_WIDTH  instruction currently fetched at `pc`.
- `pc`  out  PC_WIDTH  current fetch address.
- `running`  out  1  high in RUN.
- `done`  out  1  program finished; sticky until re-armed.
- `fault`  out  1  run ended by PC wrap rather than halt.
- `cycle_count`  out  CYC_WIDTH  non-stalled RUN cycles.

## Operation
- States: IDLE, ARMED, RUN, DONE. All outputs registered.
- IDLE: entered on reset. `start`=1 → ARMED.
- ARMED: `pc`=START_ADDR; `done`, `fault`, `cycle_count` cleared. Stays here while `start`=1. `start`=0 → RUN.
- RUN, cycle with `stall`=1: `pc` and the counter hold. `branch_en` and the halt check are ignored.
- RUN, cycle with `stall`=0, priority order:
  1. `inst_in`==HALT_INST → DONE; `pc` holds.
  2. `branch_en`=1 → `pc`<=`target`.
  3. `pc`==all ones → DONE with `fault`=1; `pc` holds.
  4. Otherwise `pc`<=`pc`+1.
  - `cycle_count` increments on every non-stalled RUN cycle, including the halting cycle.
  - Halt takes priority over a branch in the same cycle.
- DONE: `done`=1, `pc`, `fault` and `cycle_count` frozen. `start`=1 → ARMED.
- `start`=1 in any state → ARMED next cycle; a run in progress is aborted.
- Arithmetic: `pc` increment is modulo 2^PC_WIDTH, but the wrap itself is never taken; it is caught as a fault by step 3. `cycle_count` saturates at all ones.

## Timing
- Reset values, asynchronous: state=IDLE, `pc`=START_ADDR, `running`=0, `done`=0, `fault`=0, `cycle_count`=0. Reset during RUN aborts the run immediately.
- Start to run: the first edge with `start`=0 in ARMED enters RUN; `running`=1 in the following cycle, with `pc`=START_ADDR.
- Next PC: one-cycle latency; the `branch_en`/`target` sampled at edge N appear on `pc` after edge N.
- Halt: `inst_in`==HALT_INST sampled at edge N → `done`=1 and `running`=0 after edge N, `pc` still at the halt address.
- `done` stays high until the edge that samples `start`=1.
- `stall` is sampled every cycle; no combinational paths from inputs to outputs.

## Configuration
- `RUN_SEQUENCER_CYCLE_COUNT_EN` defined: counter implemented as specified above.
- Not defined: no counter register is built and `cycle_count` is tied to 0. All other behaviour is identical.

## Test plan
- Reset mid-run: reset then check outputs; run, then assert `reset` while `pc`=5 → all outputs return to reset values immediately, `pc`=0.
- Linear run: START_ADDR=0, `start` pulsed high 2 cycles then low, HALT_INST at address 4 → `pc` steps 0,1,2,3,4, then `done`=1, `pc`=4, `cycle_count`=5, `fault`=0.
- Branch/halt priority: `branch_en`=1, `target`=0x20 at `pc`=2 → next `pc`=0x20. Branch together with HALT_INST → DONE, `pc` unchanged.
- Stall: `stall`=1 for 3 cycles at `pc`=3 with HALT_INST present → no halt, `pc`=3, count frozen; release → `done` next cycle.
- Wrap fault: PC_WIDTH=4, no halt → after `pc`=15, `done`=1, `fault`=1, `pc`=15, `cycle_count`=16.
- Abort/re-arm: `start`=1 during RUN at `pc`=7 → ARMED, `pc`=0, `cycle_count`=0. Repeat with the macro undefined → `cycle_count` stays 0 throughout.
